glitch_clock_gen: RTL and testbench

Parametrised successor to the single-output fixed PLL wrapper. It runs on the PLL output clock, derives a programmable-frequency target clock for the device under test, and injects a programmable train of clock glitches at a programmable delay after a trigger. Configuration is latched when the block is armed. Everything is gated by PLL lock.

---
 rtl/glitch_clock_gen_if.sv | 33 +++
 rtl/glitch_clock_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_glitch_clock_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/glitch_clock_gen_if.sv
// Control/status bundle for glitch_clock_gen.
//   master: drives config (div_half, delay, glitch_len, glitch_gap, glitch_count) and
//           the arm/trigger/abort controls; observes target_clk, glitch_active, busy, done.
//   slave : the generator side of the same signals.
interface glitch_clock_gen_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned DLY_W = 16,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4
);
  logic [DIV_W-1:0] div_half;
  logic [DLY_W-1:0] delay;
  logic [LEN_W-1:0] glitch_len;
  logic [LEN_W-1:0] glitch_gap;
  logic [CNT_W-1:0] glitch_count;
  logic             arm;
  logic             trigger;
  logic             abort;
  logic             target_clk;
  logic             glitch_active;
  logic             busy;
  logic             done;

  modport master (
    output div_half, delay, glitch_len, glitch_gap, glitch_count, arm, trigger, abort,
    input  target_clk, glitch_active, busy, done
  );

  modport slave (
    input  div_half, delay, glitch_len, glitch_gap, glitch_count, arm, trigger, abort,
    output target_clk, glitch_active, busy, done
  );
endinterface

// File: rtl/glitch_clock_gen.sv
// Programmable target clock generator with glitch injection.
// Runs entirely on clock_in (PLL output). A free-running divider produces a 50% duty base
// clock of half-period max(div_half,1). After arming (config latched) and a trigger, a train
// of glitch_count pulses of max(glitch_len,1) cycles separated by glitch_gap cycles starts
// delay cycles later; during a pulse the target clock is inverted.
// Ports:
//   clock_in   : PLL output clock, rising-edge logic
//   reset      : asynchronous active-high reset
//   pll_locked : synchronous enable; low forces the reset state
//   bus        : glitch_clock_gen_if.slave (config, arm/trigger/abort, registered outputs)
module glitch_clock_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned DLY_W = 16,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                pll_locked,
  glitch_clock_gen_if.slave   bus
);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StDelay,
    StGlitch,
    StGap,
    StDone
  } state_e;

  state_e           state_q, state_d;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             base_clk_q, base_clk_d;

  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [LEN_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

  logic [DLY_W-1:0] cfg_delay_q, cfg_delay_d;
  logic [LEN_W-1:0] cfg_len_q, cfg_len_d;
  logic [LEN_W-1:0] cfg_gap_q, cfg_gap_d;
  logic [CNT_W-1:0] cfg_count_q, cfg_count_d;

  logic             target_clk_q, target_clk_d;
  logic             glitch_active_q, glitch_active_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIV_W-1:0] div_last;
  logic [LEN_W-1:0] len_last;

  // Terminal values: a zero setting behaves as one.
  assign div_last = (bus.div_half == '0) ? '0 : bus.div_half - DIV_W'(1);
  assign len_last = (cfg_len_q == '0) ? '0 : cfg_len_q - LEN_W'(1);

  // --------------------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------------------
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      div_cnt_q       <= '0;
      base_clk_q      <= 1'b0;
      dly_cnt_q       <= '0;
      len_cnt_q       <= '0;
      gap_cnt_q       <= '0;
      pulse_cnt_q     <= '0;
      cfg_delay_q     <= '0;
      cfg_len_q       <= '0;
      cfg_gap_q       <= '0;
      cfg_count_q     <= '0;
      target_clk_q    <= 1'b0;
      glitch_active_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      div_cnt_q       <= div_cnt_d;
      base_clk_q      <= base_clk_d;
      dly_cnt_q       <= dly_cnt_d;
      len_cnt_q       <= len_cnt_d;
      gap_cnt_q       <= gap_cnt_d;
      pulse_cnt_q     <= pulse_cnt_d;
      cfg_delay_q     <= cfg_delay_d;
      cfg_len_q       <= cfg_len_d;
      cfg_gap_q       <= cfg_gap_d;
      cfg_count_q     <= cfg_count_d;
      target_clk_q    <= target_clk_d;
      glitch_active_q <= glitch_active_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  // --------------------------------------------------------------------------------------
  // Base clock divider: independent of the FSM so its phase survives glitches and aborts.
  // div_half is used live; ">=" keeps the counter bounded if div_half shrinks mid-count.
  // --------------------------------------------------------------------------------------
  always_comb begin
    div_cnt_d  = div_cnt_q;
    base_clk_d = base_clk_q;
    if (!pll_locked) begin
      div_cnt_d  = '0;
      base_clk_d = 1'b0;
    end else if (div_cnt_q >= div_last) begin
      div_cnt_d  = '0;
      base_clk_d = ~base_clk_q;
    end else begin
      div_cnt_d  = div_cnt_q + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------------------------------
  // Next-state logic. Counters hold "cycles remaining after this one", so a counter at zero
  // marks the last cycle of its phase and never needs to wrap.
  // --------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    len_cnt_d   = len_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    cfg_delay_d = cfg_delay_q;
    cfg_len_d   = cfg_len_q;
    cfg_gap_d   = cfg_gap_q;
    cfg_count_d = cfg_count_q;

    if (!pll_locked) begin
      // Loss of lock is equivalent to reset and outranks abort/arm.
      state_d     = StIdle;
      dly_cnt_d   = '0;
      len_cnt_d   = '0;
      gap_cnt_d   = '0;
      pulse_cnt_d = '0;
      cfg_delay_d = '0;
      cfg_len_d   = '0;
      cfg_gap_d   = '0;
      cfg_count_d = '0;
    end else if (state_q != StIdle && bus.abort) begin
      state_d     = StIdle;
      dly_cnt_d   = '0;
      len_cnt_d   = '0;
      gap_cnt_d   = '0;
      pulse_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.arm) begin
            cfg_delay_d = bus.delay;
            cfg_len_d   = bus.glitch_len;
            cfg_gap_d   = bus.glitch_gap;
            cfg_count_d = bus.glitch_count;
            state_d     = StArmed;
          end
        end

        StArmed: begin
          if (bus.trigger) begin
            if (cfg_count_q == '0) begin
              state_d = StDone;
            end else if (cfg_delay_q == '0) begin
              state_d     = StGlitch;
              len_cnt_d   = len_last;
              pulse_cnt_d = cfg_count_q - CNT_W'(1);
            end else begin
              state_d   = StDelay;
              dly_cnt_d = cfg_delay_q - DLY_W'(1);
            end
          end
        end

        StDelay: begin
          if (dly_cnt_q == '0) begin
            state_d     = StGlitch;
            len_cnt_d   = len_last;
            pulse_cnt_d = cfg_count_q - CNT_W'(1);
          end else begin
            dly_cnt_d = dly_cnt_q - DLY_W'(1);
          end
        end

        StGlitch: begin
          if (len_cnt_q != '0) begin
            len_cnt_d = len_cnt_q - LEN_W'(1);
          end else if (pulse_cnt_q == '0) begin
            state_d = StDone;
          end else if (cfg_gap_q == '0) begin
            // Zero gap: next pulse follows immediately, giving one contiguous glitch.
            len_cnt_d   = len_last;
            pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
          end else begin
            state_d   = StGap;
            gap_cnt_d = cfg_gap_q - LEN_W'(1);
          end
        end

        StGap: begin
          if (gap_cnt_q == '0) begin
            state_d     = StGlitch;
            len_cnt_d   = len_last;
            pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
          end else begin
            gap_cnt_d = gap_cnt_q - LEN_W'(1);
          end
        end

        StDone: begin
          state_d = StIdle;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------------------
  // Outputs are decoded from the next state and registered, so glitch_active and the
  // inverted target clock appear in the same cycle.
  // --------------------------------------------------------------------------------------
  always_comb begin
    glitch_active_d = (state_d == StGlitch);
    busy_d          = (state_d == StArmed) || (state_d == StDelay) ||
                      (state_d == StGlitch) || (state_d == StGap);
    done_d          = (state_d == StDone);
    target_clk_d    = base_clk_d ^ glitch_active_d;
  end

  assign bus.target_clk    = target_clk_q;
  assign bus.glitch_active = glitch_active_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_glitch_clock_gen.sv
module tb_glitch_clock_gen;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned DLY_W = 16;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int          NEVER = 1 << 30;

  logic clock_in = 1'b0;
  logic reset;
  logic pll_locked;

  glitch_clock_gen_if #(
    .DIV_W(DIV_W), .DLY_W(DLY_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) bus ();

  glitch_clock_gen #(
    .DIV_W(DIV_W), .DLY_W(DLY_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .pll_locked(pll_locked),
    .bus       (bus)
  );

  always #5 clock_in = ~clock_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int k       = 0;  // rising edges since lock/reset released
  int div_n   = 3;  // effective half-period in use

  // Reference model of one armed sequence, in absolute cycle numbers
  bit m_active = 1'b0;
  int m_arm, m_trig, m_kill, m_done;
  int m_dly, m_len, m_gap, m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic lk, rs;
    lk = pll_locked;
    rs = reset;
    @(posedge clock_in);
    #1;
    cyc++;
    if (rs || reset || !lk) k = 0;
    else k++;
  endtask

  function automatic logic exp_glitch(input int c);
    int l, per, off;
    if (!m_active || m_trig < 0 || c >= m_kill || m_cnt == 0) return 1'b0;
    l   = (m_len == 0) ? 1 : m_len;
    per = l + m_gap;
    off = c - (m_trig + 1 + m_dly);
    return (off >= 0) && (off < m_cnt * per) && ((off % per) < l);
  endfunction

  function automatic logic exp_busy(input int c);
    return m_active && (c > m_arm) && (c < m_kill) && (m_trig < 0 || c < m_done);
  endfunction

  function automatic logic exp_done(input int c);
    return m_active && (m_trig >= 0) && (c == m_done) && (c < m_kill);
  endfunction

  task automatic check_all();
    logic g, b;
    g = exp_glitch(cyc);
    b = 1'(((k / div_n) % 2));
    check_eq("glitch_active", bus.glitch_active, g);
    check_eq("target_clk", bus.target_clk, b ^ g);
    check_eq("busy", bus.busy, exp_busy(cyc));
    check_eq("done", bus.done, exp_done(cyc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all();
      bus.arm     = 1'b0;
      bus.trigger = 1'($urandom_range(0, 1));  // ignored outside ARMED
      bus.abort   = 1'($urandom_range(0, 1));
    end
    bus.trigger = 1'b0;
    bus.abort   = 1'b0;
  endtask

  task automatic relock(input int new_div);
    pll_locked = 1'b0;
    idle(3);
    bus.div_half = DIV_W'(new_div);
    div_n        = (new_div == 0) ? 1 : new_div;
    pll_locked   = 1'b1;
    idle(2);
  endtask

  // Arm in the current cycle, trigger wait_n cycles later; optional abort, lock drop or
  // async reset at the given offsets from the trigger cycle (negative = none).
  task automatic run_seq(input int dly, input int len, input int gap, input int cnt,
                         input int wait_n, input int abort_off, input int drop_off,
                         input int rst_off, input bit rearm);
    int t_c, abort_c, drop_c, rst_c, fin;
    bus.delay        = DLY_W'(dly);
    bus.glitch_len   = LEN_W'(len);
    bus.glitch_gap   = LEN_W'(gap);
    bus.glitch_count = CNT_W'(cnt);
    bus.arm          = 1'b1;
    bus.trigger      = 1'b0;
    bus.abort        = 1'($urandom_range(0, 1));  // arm wins over abort in IDLE
    m_active = 1'b1;
    m_arm    = cyc;
    m_trig   = -1;
    m_kill   = NEVER;
    m_dly    = dly;
    m_len    = len;
    m_gap    = gap;
    m_cnt    = cnt;
    t_c      = cyc + wait_n;
    m_done   = (cnt == 0) ? t_c + 1 :
               t_c + 1 + dly + cnt * ((len == 0) ? 1 : len) + (cnt - 1) * gap;
    abort_c  = (abort_off < 0) ? -1 : t_c + abort_off;
    drop_c   = (drop_off < 0) ? -1 : t_c + drop_off;
    rst_c    = (rst_off < 0) ? -1 : t_c + rst_off;
    fin      = 0;
    for (int i = 0; i < 600 && fin == 0; i++) begin
      tick();
      if (rst_c >= 0 && cyc == rst_c + 1) reset = 1'b0;
      check_all();
      if (cyc == rst_c) begin
        #2 reset = 1'b1;
        #1;
        m_kill = cyc;
        k      = 0;
        check_eq("rst_target_clk", bus.target_clk, 1'b0);
        check_eq("rst_glitch_active", bus.glitch_active, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
      end
      bus.arm     = 1'b0;
      bus.trigger = (cyc == t_c);
      bus.abort   = (cyc == abort_c);
      if (cyc == t_c) m_trig = t_c;
      // Latched config must not follow the live inputs after arming
      bus.delay        = DLY_W'($urandom);
      bus.glitch_len   = LEN_W'($urandom);
      bus.glitch_gap   = LEN_W'($urandom);
      bus.glitch_count = CNT_W'($urandom);
      if (rearm && cyc == t_c) bus.arm = 1'b1;
      if (cyc == abort_c && cyc + 1 < m_kill) m_kill = cyc + 1;
      if (drop_c >= 0) begin
        pll_locked = !(cyc >= drop_c && cyc < drop_c + 3);
        if (cyc == drop_c && cyc + 1 < m_kill) m_kill = cyc + 1;
      end
      if (m_trig >= 0 && cyc >= ((m_done < m_kill) ? m_done : m_kill) + 5) fin = 1;
    end
    if (fin == 0) check_eq("seq_timeout", 32'd0, 32'd1);
    m_active    = 1'b0;
    bus.arm     = 1'b0;
    bus.trigger = 1'b0;
    bus.abort   = 1'b0;
    reset       = 1'b0;
    pll_locked  = 1'b1;
  endtask

  initial begin
    int d, l, g, n, ab, span;
    reset            = 1'b1;
    pll_locked       = 1'b0;
    bus.div_half     = DIV_W'(3);
    bus.delay        = '0;
    bus.glitch_len   = '0;
    bus.glitch_gap   = '0;
    bus.glitch_count = '0;
    bus.arm          = 1'b0;
    bus.trigger      = 1'b0;
    bus.abort        = 1'b0;
    #3;
    check_eq("reset_target_clk", bus.target_clk, 1'b0);
    check_eq("reset_busy", bus.busy, 1'b0);
    tick();
    tick();
    check_all();
    reset = 1'b0;
    idle(3);          // unlocked: held at reset state
    pll_locked = 1'b1;
    idle(14);         // divide-by-6 clock, no glitches

    run_seq(10, 2, 3, 3, 3, -1, -1, -1, 1'b0);
    idle(4);
    run_seq(0, 0, 2, 1, 1, -1, -1, -1, 1'b1);
    idle(3);
    run_seq(7, 1, 1, 0, 2, -1, -1, -1, 1'b0);
    idle(3);
    run_seq(4, 2, 3, 3, 2, 8, -1, -1, 1'b1);   // abort in the middle of the first gap
    idle(5);
    run_seq(4, 3, 1, 2, 2, -1, 6, -1, 1'b0);   // lock lost during the first pulse
    idle(4);
    run_seq(8, 1, 1, 1, 2, -1, -1, 3, 1'b0);   // async reset during the delay
    idle(4);

    for (int s = 0; s < 30; s++) begin
      if (s % 6 == 5) relock($urandom_range(0, 5));
      d    = $urandom_range(0, 12);
      l    = $urandom_range(0, 3);
      g    = $urandom_range(0, 3);
      n    = $urandom_range(0, 4);
      span = d + n * (l + 1) + n * g + 2;
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, span) : -1;
      run_seq(d, l, g, n, $urandom_range(1, 4), ab, -1, -1, 1'($urandom_range(0, 1)));
      idle($urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
